vmul_mul_arbiter: RTL and testbench

VMUL_MUL_ARBITER -- requirements
Module: vmul_mul_arbiter

---
 rtl/vmul_mul_arb_pkg.sv | 17 +
 rtl/vmul_mul_arb_rr.sv | 34 +++
 rtl/vmul_mul_arbiter.sv | 137 +++++++++++++
 tb/tb_vmul_mul_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vmul_mul_arb_pkg.sv
// Shared constants and types for the round-robin multiplier arbiter.
package vmul_mul_arb_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int NUM_REQ_DEFAULT    = 4;
  localparam int ID_WIDTH_DEFAULT   = $clog2(NUM_REQ_DEFAULT);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/vmul_mul_arb_rr.sv
// Combinational round-robin pick: lowest valid index at or after rr_ptr, wrapping.
module vmul_mul_arb_rr #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic found;

  // Indices below rr_ptr are the wrapped tail; indices at/after rr_ptr override them.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    grant     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid[i] && (ID_W'(i) < rr_ptr)) begin
        grant_idx = ID_W'(i);
        found     = 1'b1;
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid[i] && (ID_W'(i) >= rr_ptr)) begin
        grant_idx = ID_W'(i);
        found     = 1'b1;
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/vmul_mul_arbiter.sv
// Round-robin arbiter in front of a shared signed multiplier with a one-entry output register.
// Optional rsp_ovf overflow flag is enabled by defining VMUL_MUL_ARBITER_OVF_EN.
//
// state | meaning
// EMPTY | output register holds no result, rsp_valid=0
// FULL  | output register holds a result awaiting rsp_ready
module vmul_mul_arbiter
  import vmul_mul_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id
`ifdef VMUL_MUL_ARBITER_OVF_EN
  ,
  output logic                          rsp_ovf
`endif
);

  localparam int ID_W = id_width(NUM_REQ);

  arb_state_e                   state_q, state_d;
  logic [ID_W-1:0]              rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0]        rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]              rsp_id_q, rsp_id_d;

  logic [NUM_REQ-1:0]           grant;
  logic [ID_W-1:0]              grant_idx;
  logic                         can_accept;
  logic                         hs;
  logic signed [DATA_WIDTH-1:0] a_sel, b_sel;
  logic [DATA_WIDTH-1:0]        prod_lo;

`ifdef VMUL_MUL_ARBITER_OVF_EN
  logic                           rsp_ovf_q, rsp_ovf_d;
  logic                           ovf;
  logic signed [2*DATA_WIDTH-1:0] prod_full;
`endif

  vmul_mul_arb_rr #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .valid     (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_idx) begin
        a_sel = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        b_sel = req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef VMUL_MUL_ARBITER_OVF_EN
  // Overflow when the upper half plus the result sign bit are not all-equal.
  always_comb begin
    prod_full = a_sel * b_sel;
    prod_lo   = prod_full[DATA_WIDTH-1:0];
    ovf       = !((&prod_full[2*DATA_WIDTH-1:DATA_WIDTH-1]) ||
                  (~|prod_full[2*DATA_WIDTH-1:DATA_WIDTH-1]));
  end
`else
  always_comb begin
    prod_lo = a_sel * b_sel;
  end
`endif

  always_comb begin
    can_accept = (state_q == EMPTY) || rsp_ready;
    req_ready  = can_accept ? grant : '0;
    hs         = |(req_valid & req_ready);

    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
`ifdef VMUL_MUL_ARBITER_OVF_EN
    rsp_ovf_d  = rsp_ovf_q;
`endif

    if (hs) begin
      state_d    = FULL;
      rsp_data_d = prod_lo;
      rsp_id_d   = grant_idx;
      rr_ptr_d   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
`ifdef VMUL_MUL_ARBITER_OVF_EN
      rsp_ovf_d  = ovf;
`endif
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= EMPTY;
      rr_ptr_q   <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
`ifdef VMUL_MUL_ARBITER_OVF_EN
      rsp_ovf_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
`ifdef VMUL_MUL_ARBITER_OVF_EN
      rsp_ovf_q  <= rsp_ovf_d;
`endif
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
`ifdef VMUL_MUL_ARBITER_OVF_EN
  assign rsp_ovf   = rsp_ovf_q;
`endif

endmodule

// File: tb/tb_vmul_mul_arbiter.sv
// Scoreboard bench for vmul_mul_arbiter: reference model predicts grants and products,
// an independent monitor compares every presented result.
module tb_vmul_mul_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  typedef struct {
    logic [1:0]    id;
    logic [DW-1:0] data;
    logic          ovf;
  } exp_t;

  logic            ap_clk = 1'b0;
  logic            ap_rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a = '0;
  logic [N*DW-1:0] req_b = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [DW-1:0]   rsp_data;
  logic [1:0]      rsp_id;
`ifdef VMUL_MUL_ARBITER_OVF_EN
  logic            rsp_ovf;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  vmul_mul_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef VMUL_MUL_ARBITER_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: search from the pointer, one-entry output buffer.
  int              m_ptr = 0;
  bit              m_full = 1'b0;
  int              g;
  logic [N-1:0]    exp_rdy;
  logic signed [DW-1:0] ma, mb;
  longint          prod;
  exp_t            me;

  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      m_full = 1'b0;
      m_ptr  = 0;
      sb.delete();
    end else begin
      check("rsp_valid", 32'(rsp_valid), 32'(m_full));
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      exp_rdy = '0;
      if ((!m_full || rsp_ready) && g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (exp_rdy != '0) begin
        ma      = req_a[g*DW +: DW];
        mb      = req_b[g*DW +: DW];
        prod    = longint'(ma) * longint'(mb);
        me.id   = 2'(g);
        me.data = prod[DW-1:0];
        me.ovf  = (prod > 64'sd2147483647) || (prod < -64'sd2147483648);
        sb.push_back(me);
        m_ptr  = (g + 1) % N;
        m_full = 1'b1;
      end else if (m_full && rsp_ready) begin
        m_full = 1'b0;
      end
    end
  end

  exp_t mon_e;

  always @(negedge ap_clk) begin
    if (ap_rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_rsp: got id %0d data %h, required no response", rsp_id, rsp_data);
      end else begin
        mon_e = sb[0];
        check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        check("rsp_data", rsp_data, mon_e.data);
`ifdef VMUL_MUL_ARBITER_OVF_EN
        check("rsp_ovf", 32'(rsp_ovf), 32'(mon_e.ovf));
`endif
        if (rsp_ready) mon_e = sb.pop_front();
      end
    end
  end

  task automatic cyc(input logic [N-1:0] v, input logic rr);
    @(posedge ap_clk);
    #1;
    req_valid = v;
    rsp_ready = rr;
  endtask

  task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  function automatic logic [DW-1:0] rnd_val();
    logic [DW-1:0] tbl [6];
    tbl[0] = 32'h0;
    tbl[1] = 32'h1;
    tbl[2] = 32'hFFFF_FFFF;
    tbl[3] = 32'h7FFF_FFFF;
    tbl[4] = 32'h8000_0000;
    tbl[5] = 32'h0001_0000;
    if ($urandom_range(0, 7) == 0) return tbl[$urandom_range(0, 5)];
    if ($urandom_range(0, 1) == 0) return DW'($urandom_range(0, 200)) - 32'd100;
    return $urandom;
  endfunction

  task automatic rnd_ops();
    for (int i = 0; i < N; i++) set_op(i, rnd_val(), rnd_val());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) cyc('0, 1'b0);
    @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b1;

    // Single request 7 * -3
    set_op(0, 32'd7, 32'hFFFF_FFFD);
    cyc(4'b0001, 1'b1);
    cyc(4'b0000, 1'b1);
    @(negedge ap_clk);
    check("single_data", rsp_data, 32'hFFFF_FFEB);
    check("single_id", 32'(rsp_id), 32'd0);

    // All four valid continuously
    for (int c = 0; c < 8; c++) begin
      rnd_ops();
      cyc(4'b1111, 1'b1);
    end

    // Backpressure then release
    cyc(4'b1111, 1'b0);
    for (int c = 0; c < 5; c++) begin
      cyc(4'b1111, 1'b0);
      @(negedge ap_clk);
      check("bp_ready_zero", 32'(req_ready), 32'd0);
    end
    cyc(4'b1111, 1'b1);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);

    // Wrap cases
    set_op(2, 32'h0001_0000, 32'h0001_0000);
    cyc(4'b0100, 1'b1);
    cyc(4'b0000, 1'b1);
    @(negedge ap_clk);
    check("wrap_zero", rsp_data, 32'h0);
    set_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cyc(4'b0100, 1'b1);
    cyc(4'b0000, 1'b1);
    @(negedge ap_clk);
    check("neg_one_sq", rsp_data, 32'h1);

    // Sparse: only req1 moves the pointer to 2, then req3 beats req1
    rnd_ops();
    cyc(4'b0010, 1'b1);
    cyc(4'b1010, 1'b1);
    @(negedge ap_clk);
    check("sparse_grant3", 32'(req_ready), 32'h8);
    cyc(4'b0000, 1'b1);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      rnd_ops();
      cyc(4'($urandom_range(0, 15)), $urandom_range(0, 9) < 7);
    end
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);

    // Reset while FULL
    set_op(0, 32'd5, 32'd6);
    cyc(4'b0001, 1'b0);
    @(posedge ap_clk);
    #3;
    ap_rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(rsp_valid), 32'd0);
    req_valid = '0;
    repeat (2) cyc(4'b0000, 1'b0);
    @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b1;
    rnd_ops();
    cyc(4'b1110, 1'b1);
    @(negedge ap_clk);
    check("post_rst_grant", 32'(req_ready), 32'h2);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);
    @(negedge ap_clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
